// File: rtl/fill_ctrl_pkg.sv
// Shared definitions for the fill RAM controller: bank count, default phase timeout,
// counter geometry, controller state encoding and a lowest-set-bit helper.
package fill_ctrl_pkg;

    localparam int unsigned NUM_CH         = 2;
    localparam logic [31:0] TIMEOUT_CYCLES = 32'd400_000_000;
    localparam int unsigned ELAPSED_W      = 64;
    localparam int unsigned TIMER_W        = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StRun    = 2'd2,
        StFinish = 2'd3
    } fill_state_e;

    // Isolates the lowest set bit; returns zero when nothing is set.
    function automatic logic [NUM_CH-1:0] lowest_bit(input logic [NUM_CH-1:0] vec);
        lowest_bit = vec & (~vec + NUM_CH'(1));
    endfunction

endpackage

// File: rtl/fill_ch_handshake.sv
// Per-bank start/acknowledge/complete tracker for one fill engine.
// An idle-low seen during the launch window is remembered until the window closes,
// so a bank that answers early stays acknowledged while the others catch up.
module fill_ch_handshake (
    input  logic clk_i,
    input  logic rst_i,
    input  logic launch_i,
    input  logic active_i,
    input  logic fill_idle_i,
    output logic ack_o,
    output logic complete_o
);

    logic ack_q, ack_d;

    // Acknowledge memory: set on idle-low while launching, cleared outside the window.
    always_comb begin
        ack_d = ack_q;
        if (!launch_i) begin
            ack_d = 1'b0;
        end else if (active_i && !fill_idle_i) begin
            ack_d = 1'b1;
        end
    end

    // Acknowledge register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    // Banks outside the phase mask never hold the controller back.
    assign ack_o      = !active_i || ack_q || !fill_idle_i;
    assign complete_o = !active_i || fill_idle_i;

endmodule

// File: rtl/fill_ram_ctrl.sv
// Fill RAM erase sequencer: launches the enabled fill engines in parallel or one after the
// other, waits for each phase to complete, and reports busy/done/elapsed.
// Optional feature macro: FILL_RAM_CTRL_TIMEOUT_EN adds a per-phase timeout that raises error.
module fill_ram_ctrl #(
    parameter int unsigned NUM_CH         = fill_ctrl_pkg::NUM_CH,
    parameter logic [31:0] TIMEOUT_CYCLES = fill_ctrl_pkg::TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [NUM_CH-1:0]                  chan_en,
    input  logic                               sequential,
    output logic [NUM_CH-1:0]                  fill_start,
    input  logic [NUM_CH-1:0]                  fill_idle,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [fill_ctrl_pkg::ELAPSED_W-1:0] elapsed
);

    import fill_ctrl_pkg::*;

    fill_state_e            state_q, state_d;
    logic [NUM_CH-1:0]      en_q, en_d;
    logic                   seq_q, seq_d;
    logic [NUM_CH-1:0]      ran_q, ran_d;
    logic [NUM_CH-1:0]      fill_start_q, fill_start_d;
    logic [ELAPSED_W-1:0]   elapsed_q, elapsed_d;
    logic [NUM_CH-1:0]      phase_mask;
    logic [NUM_CH-1:0]      ack;
    logic [NUM_CH-1:0]      complete;
    logic                   in_launch;

`ifdef FILL_RAM_CTRL_TIMEOUT_EN
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   error_q, error_d;
    logic                   timed_out;
`endif

    assign in_launch  = (state_q == StLaunch);
    // Banks taking part in the current phase.
    assign phase_mask = seq_q ? lowest_bit(en_q & ~ran_q) : en_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fill_ch_handshake u_hs (
            .clk_i       (clk),
            .rst_i       (reset),
            .launch_i    (in_launch),
            .active_i    (phase_mask[i]),
            .fill_idle_i (fill_idle[i]),
            .ack_o       (ack[i]),
            .complete_o  (complete[i])
        );
    end

`ifdef FILL_RAM_CTRL_TIMEOUT_EN
    assign timed_out = (state_q == StLaunch || state_q == StRun) &&
                       (timer_q >= TIMEOUT_CYCLES - 32'd1);
`endif

    // Sequencer next-state, latched configuration and elapsed counter.
    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        seq_d        = seq_q;
        ran_d        = ran_q;
        fill_start_d = fill_start_q;
        elapsed_d    = elapsed_q;
`ifdef FILL_RAM_CTRL_TIMEOUT_EN
        error_d      = error_q;
        timer_d      = timer_q;
`endif

        if (state_q != StIdle && elapsed_q != '1) begin
            elapsed_d = elapsed_q + 64'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start && chan_en != '0) begin
                    en_d         = chan_en;
                    seq_d        = sequential;
                    ran_d        = '0;
                    elapsed_d    = '0;
                    fill_start_d = sequential ? lowest_bit(chan_en) : chan_en;
                    state_d      = StLaunch;
`ifdef FILL_RAM_CTRL_TIMEOUT_EN
                    error_d      = 1'b0;
`endif
                end
            end
            StLaunch: begin
                if (&ack) begin
                    fill_start_d = '0;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (&complete) begin
                    ran_d = ran_q | phase_mask;
                    if (seq_q && (en_q & ~ran_d) != '0) begin
                        fill_start_d = lowest_bit(en_q & ~ran_d);
                        state_d      = StLaunch;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef FILL_RAM_CTRL_TIMEOUT_EN
        // A stuck phase abandons the sequence; the timeout wins over a same-cycle completion.
        if (timed_out) begin
            error_d      = 1'b1;
            fill_start_d = '0;
            state_d      = StFinish;
        end
        if (state_d == StLaunch && state_q != StLaunch) begin
            timer_d = '0;
        end else if (state_q == StLaunch || state_q == StRun) begin
            timer_d = timer_q + 32'd1;
        end
`endif
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            en_q         <= '0;
            seq_q        <= 1'b0;
            ran_q        <= '0;
            fill_start_q <= '0;
            elapsed_q    <= '0;
`ifdef FILL_RAM_CTRL_TIMEOUT_EN
            error_q      <= 1'b0;
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            seq_q        <= seq_d;
            ran_q        <= ran_d;
            fill_start_q <= fill_start_d;
            elapsed_q    <= elapsed_d;
`ifdef FILL_RAM_CTRL_TIMEOUT_EN
            error_q      <= error_d;
            timer_q      <= timer_d;
`endif
        end
    end

    assign fill_start = fill_start_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFinish);
    assign elapsed    = elapsed_q;
`ifdef FILL_RAM_CTRL_TIMEOUT_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_fill_ram_ctrl.sv
// Bench for fill_ram_ctrl: behavioural fill engines, a phase-timeline reference model,
// a table of hand-derived vectors, randomized runs and directed corner sequences.
`timescale 1ns/1ps
module tb_fill_ram_ctrl;

`ifdef FILL_RAM_CTRL_TIMEOUT_EN
    localparam logic [31:0] TO = 32'd50;
`else
    localparam logic [31:0] TO = 32'd400_000_000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  chan_en;
    logic        sequential;
    logic [1:0]  fill_start;
    logic [1:0]  fill_idle;
    logic        busy;
    logic        done;
    logic        error;
    logic [63:0] elapsed;

    fill_ram_ctrl #(
        .NUM_CH         (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .chan_en    (chan_en),
        .sequential (sequential),
        .fill_start (fill_start),
        .fill_idle  (fill_idle),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .elapsed    (elapsed)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    // Engine model: launch cycle (-1 = idle), idle-drop delay, busy length.
    int lc[2];
    int ea[2];
    int eb[2];
    // Observed run results.
    int r_done, r_ndone, r_c0, r_c1, r_f0, r_f1, r_outside;
    int r_err, r_err1, r_err_after, r_busy, r_fs_after;
    longint r_elapsed;
    // Model results.
    int m_done, m_c0, m_c1, m_f0, m_f1;
    int last_el;

    typedef struct {
        logic [1:0] en;
        logic       sq;
        int a0; int a1; int b0; int b1;
        int el; int c0; int c1; int f0; int f1;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance one cycle, then update the engine models from the new fill_start.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (lc[i] < 0 && fill_start[i]) lc[i] = cyc;
            if (lc[i] >= 0 && cyc >= lc[i] + ea[i] + eb[i]) lc[i] = -1;
            fill_idle[i] = !(lc[i] >= 0 && cyc >= lc[i] + ea[i]);
        end
    endtask

    // Timeline from the rules: each phase launches at L, holds fill_start until the slowest
    // masked engine drops idle, ends when the last one returns idle; next step is end+1.
    function automatic void model(input logic [1:0] en, input logic sq,
                                  input int a0, input int a1, input int b0, input int b1);
        int a[2];
        int b[2];
        logic [1:0] ph[$];
        int l;
        int mx_a;
        int endc;
        a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1;
        if (sq) begin
            if (en[0]) ph.push_back(2'b01);
            if (en[1]) ph.push_back(2'b10);
        end else begin
            ph.push_back(en);
        end
        m_c0 = 0; m_c1 = 0; m_f0 = -1; m_f1 = -1; l = 1;
        foreach (ph[p]) begin
            mx_a = 0; endc = 0;
            for (int i = 0; i < 2; i++) begin
                if (ph[p][i]) begin
                    if (a[i] > mx_a) mx_a = a[i];
                    if (l + a[i] + b[i] > endc) endc = l + a[i] + b[i];
                end
            end
            if (ph[p][0]) begin m_c0 += mx_a + 1; m_f0 = l; end
            if (ph[p][1]) begin m_c1 += mx_a + 1; m_f1 = l; end
            l = endc + 1;
        end
        m_done = l;
    endfunction

    // One sequence; poke>0 fires ignored starts at relative cycles poke and poke+1.
    task automatic run_seq(input logic [1:0] en, input logic sq, input int a0, input int a1,
                           input int b0, input int b1, input int poke);
        ea[0] = a0; ea[1] = a1; eb[0] = b0; eb[1] = b1;
        lc[0] = -1; lc[1] = -1; fill_idle = 2'b11;
        r_done = -1; r_ndone = 0; r_c0 = 0; r_c1 = 0; r_f0 = -1; r_f1 = -1;
        r_outside = 0; r_err = 0; r_err1 = 0;
        chan_en = en; sequential = sq; start = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (k == 1) r_err1 = int'(error);
            if (poke > 0 && k == poke) begin
                start = 1'b1; chan_en = 2'b01; sequential = ~sq;
            end else if (poke > 0 && k == poke + 1) begin
                start = 1'b1; chan_en = 2'b00; sequential = sq;
            end else begin
                start = 1'b0; chan_en = en; sequential = sq;
            end
            if (fill_start[0]) begin r_c0++; if (r_f0 < 0) r_f0 = k; end
            if (fill_start[1]) begin r_c1++; if (r_f1 < 0) r_f1 = k; end
            if (fill_start != 2'b00 && !busy) r_outside++;
            if (done) begin
                r_ndone++;
                if (r_ndone == 1) begin r_done = k; r_err = int'(error); end
            end
            if (r_ndone > 0 && k >= r_done + 3) break;
        end
        start = 1'b0;
        r_elapsed   = longint'(elapsed);
        r_busy      = int'(busy);
        r_fs_after  = int'(fill_start);
        r_err_after = int'(error);
    endtask

    task automatic chk_run(input string tag, input int e_done, input int e_c0, input int e_c1,
                           input int e_f0, input int e_f1, input int e_err);
        chk({tag, ".done_cycle"}, r_done, e_done);
        chk({tag, ".done_count"}, r_ndone, 1);
        chk({tag, ".elapsed"}, r_elapsed, e_done);
        chk({tag, ".fs0_cycles"}, r_c0, e_c0);
        chk({tag, ".fs1_cycles"}, r_c1, e_c1);
        chk({tag, ".fs0_first"}, r_f0, e_f0);
        chk({tag, ".fs1_first"}, r_f1, e_f1);
        chk({tag, ".error_at_done"}, r_err, e_err);
        chk({tag, ".error_after"}, r_err_after, e_err);
        chk({tag, ".error_cleared_on_start"}, r_err1, 0);
        chk({tag, ".fs_outside_busy"}, r_outside, 0);
        chk({tag, ".busy_after"}, r_busy, 0);
        chk({tag, ".fs_after"}, r_fs_after, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cd, cb, cf;
        int poke;
        logic [1:0] ren;
        logic rsq;
        int ra0, ra1, rb0, rb1;

        reset = 1'b1; start = 1'b0; chan_en = 2'b00; sequential = 1'b0; fill_idle = 2'b11;
        for (int i = 0; i < 2; i++) begin lc[i] = -1; ea[i] = 1; eb[i] = 1; end

        tick();
        tick();
        chk("reset.busy", longint'(busy), 0);
        chk("reset.done", longint'(done), 0);
        chk("reset.error", longint'(error), 0);
        chk("reset.fill_start", longint'(fill_start), 0);
        chk("reset.elapsed", longint'(elapsed), 0);
        reset = 1'b0;
        tick();

`ifdef FILL_RAM_CTRL_TIMEOUT_EN
        // Engine never drops idle: timeout after 50 phase cycles.
        run_seq(2'b01, 1'b0, 100000, 1, 10, 10, 0);
        chk_run("timeout", 51, 50, 0, 1, -1, 1);
        run_seq(2'b01, 1'b0, 2, 1, 10, 10, 0);
        model(2'b01, 1'b0, 2, 1, 10, 10);
        chk_run("after_timeout", m_done, m_c0, m_c1, m_f0, m_f1, 0);
        last_el = m_done;
`else
        tbl[0] = '{2'b11, 1'b0, 3, 5, 100, 100, 107, 6, 6, 1, 1};
        tbl[1] = '{2'b11, 1'b1, 3, 5, 100, 100, 211, 4, 6, 1, 105};
        tbl[2] = '{2'b10, 1'b1, 3, 5, 100, 100, 107, 0, 6, -1, 1};
        tbl[3] = '{2'b01, 1'b0, 2, 1, 10, 10, 14, 3, 0, 1, -1};
        tbl[4] = '{2'b01, 1'b1, 2, 1, 10, 10, 14, 3, 0, 1, -1};
        tbl[5] = '{2'b10, 1'b0, 1, 1, 1, 1, 4, 0, 2, -1, 1};
        tbl[6] = '{2'b11, 1'b0, 1, 1, 1, 1, 4, 2, 2, 1, 1};
        tbl[7] = '{2'b11, 1'b1, 2, 4, 10, 20, 39, 3, 5, 1, 14};
        for (int i = 0; i < 8; i++) begin
            run_seq(tbl[i].en, tbl[i].sq, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, 0);
            chk_run($sformatf("tbl%0d", i), tbl[i].el, tbl[i].c0, tbl[i].c1,
                    tbl[i].f0, tbl[i].f1, 0);
        end

        for (int i = 0; i < 20; i++) begin
            ren = 2'($urandom_range(1, 3));
            rsq = 1'($urandom_range(0, 1));
            ra0 = int'($urandom_range(1, 8));
            ra1 = int'($urandom_range(1, 8));
            rb0 = int'($urandom_range(10, 40));
            rb1 = int'($urandom_range(10, 40));
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : 0;
            run_seq(ren, rsq, ra0, ra1, rb0, rb1, poke);
            model(ren, rsq, ra0, ra1, rb0, rb1);
            chk_run($sformatf("rnd%0d", i), m_done, m_c0, m_c1, m_f0, m_f1, 0);
        end

        // Starts while busy must not disturb the running sequence.
        run_seq(2'b11, 1'b0, 3, 5, 30, 30, 10);
        model(2'b11, 1'b0, 3, 5, 30, 30);
        chk_run("busy_start", m_done, m_c0, m_c1, m_f0, m_f1, 0);
        last_el = m_done;
`endif

        // start with chan_en == 0 is ignored.
        cd = 0; cb = 0; cf = 0;
        chan_en = 2'b00; sequential = 1'b1; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            start = 1'b0; chan_en = 2'b11;
            if (done) cd++;
            if (busy) cb++;
            if (fill_start != 2'b00) cf++;
        end
        chk("en0.done", cd, 0);
        chk("en0.busy", cb, 0);
        chk("en0.fill_start", cf, 0);
        chk("en0.elapsed", longint'(elapsed), last_el);

        // Reset during RUN: outputs clear at once, no done, engines finish on their own.
        ea[0] = 3; ea[1] = 5; eb[0] = 30; eb[1] = 30;
        lc[0] = -1; lc[1] = -1; fill_idle = 2'b11;
        chan_en = 2'b11; sequential = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        chk("rst_mid.busy_before", longint'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.busy", longint'(busy), 0);
        chk("rst_mid.done", longint'(done), 0);
        chk("rst_mid.error", longint'(error), 0);
        chk("rst_mid.fill_start", longint'(fill_start), 0);
        chk("rst_mid.elapsed", longint'(elapsed), 0);
        cd = 0; cf = 0; cb = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (k == 1) reset = 1'b0;
            if (done) cd++;
            if (busy) cb++;
            if (fill_start != 2'b00) cf++;
        end
        chk("rst_mid.no_done", cd, 0);
        chk("rst_mid.no_busy", cb, 0);
        chk("rst_mid.no_fill_start", cf, 0);

        run_seq(2'b11, 1'b1, 2, 3, 10, 12, 0);
        model(2'b11, 1'b1, 2, 3, 10, 12);
        chk_run("post_reset", m_done, m_c0, m_c1, m_f0, m_f1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fill_ram_ctrl.md
FILL_RAM_CTRL -- requirements
Module: fill_ram_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of fill engines sequenced (fixed at 2; other values unsupported).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd400_000_000, meaning the maximum cycles a phase may take before an error is raised.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin an erase sequence, synchronous to clk.
REQ-006 SHALL have port chan_en, input, 2 bits: bit i enables bank i; sampled on accepted start.
REQ-007 SHALL have port sequential, input, 1 bit: 1 runs bank 0 then bank 1; 0 runs both together; sampled on accepted start.
REQ-008 SHALL have port fill_start, output, 2 bits: level start to fill engine i (crosses into the engine's synchronizer).
REQ-009 SHALL have port fill_idle, input, 2 bits: idle status from fill engine i.
REQ-010 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence ends, on success or error.
REQ-012 SHALL have port error, output, 1 bit: sticky timeout flag, cleared on the next accepted start.
REQ-013 SHALL have port elapsed, output, 64 bits: cycles from accepted start to done.

Function
REQ-014 SHALL implement the states IDLE, LAUNCH, RUN and FINISH.
REQ-015 IDLE: a start with chan_en!=0 SHALL be accepted, latch chan_en and sequential, clear elapsed and error, set busy, and go to LAUNCH on the next cycle.
REQ-016 IDLE: start with chan_en==0 SHALL be ignored, with no done pulse.
REQ-017 The phase mask SHALL be: parallel = latched chan_en; sequential = lowest-numbered enabled bank not yet run.
REQ-018 LAUNCH SHALL drive fill_start = phase mask and hold it until every masked fill_idle bit has been observed low, then deassert fill_start and go to RUN.
REQ-019 Each masked bank's idle-low acknowledge SHALL be tracked individually; a bank that acknowledged early SHALL stay acknowledged.
REQ-020 RUN SHALL wait until all masked fill_idle bits are high.
REQ-021 On leaving RUN: if sequential and an enabled bank remains, go to LAUNCH; else go to FINISH.
REQ-022 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-023 start during busy SHALL be ignored, with no queuing.
REQ-024 elapsed SHALL increment every cycle while busy, freeze at done, and hold until the next accepted start; it saturates at all-ones, with no wrap.
REQ-025 fill_start SHALL never be high outside LAUNCH.
REQ-026 Latency: start at cycle N -> busy high at N+1 -> fill_start high at N+1.

Reset
REQ-027 Asserting reset SHALL immediately set state=IDLE, fill_start=0, busy=0, done=0, error=0, elapsed=0 and all latched masks to 0.
REQ-028 Reset mid-sequence SHALL abandon the sequence with no done pulse; the engines finish independently.

Configuration
REQ-029 The macro FILL_RAM_CTRL_TIMEOUT_EN SHALL control the timeout feature.
REQ-030 With FILL_RAM_CTRL_TIMEOUT_EN defined, a per-phase cycle counter SHALL clear on entering LAUNCH and count through LAUNCH+RUN.
REQ-031 With FILL_RAM_CTRL_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set error, drop fill_start and go to FINISH.
REQ-032 Without FILL_RAM_CTRL_TIMEOUT_EN, error SHALL be tied 0, no timeout counter SHALL exist, and phases wait indefinitely.

Structure
REQ-033 State encodings, NUM_CH and the default TIMEOUT_CYCLES SHALL live in the shared package fill_ctrl_pkg, alongside the geometry constants.
REQ-034 One sub-module, fill_ch_handshake (per-bank start/ack/complete tracker), SHALL be instantiated NUM_CH times.

Verification
REQ-035 The bench SHALL cover: parallel, chan_en=2'b11; both engine models drop idle 3 and 5 cycles after fill_start, raise it 100 cycles later -> fill_start high cycles 1..6, done at the cycle after both are idle, elapsed ~= 107, error=0.
REQ-036 The bench SHALL cover: sequential, chan_en=2'b11 -> fill_start[1] never high until fill_idle[0] returns high; done once; elapsed = sum of both phases + overhead.
REQ-037 The bench SHALL cover: chan_en=2'b10, sequential -> only fill_start[1] asserted; fill_start[0] stays 0 throughout.
REQ-038 The bench SHALL cover: TIMEOUT_EN defined, TIMEOUT_CYCLES=50, engine never drops idle -> error=1 and done at cycle ~51, fill_start=0 afterward; next start clears error.
REQ-039 The bench SHALL cover: reset asserted during RUN -> all outputs 0 in the same cycle, no done; a later start runs normally.
REQ-040 The bench SHALL cover: start pulsed while busy and start with chan_en=0 -> no effect on state, elapsed or done.
